// File: rtl/cnt_arb_ctrl_if.sv
// Requester-side bundle for cnt_arb_ctrl: run requests in, grant and completion status out.
interface cnt_arb_ctrl_if #(
  parameter int LEN_WDTH = 4
);
  logic [1:0]          req;
  logic [1:0]          req_dir;
  logic [LEN_WDTH-1:0] req_len0;
  logic [LEN_WDTH-1:0] req_len1;
  logic [1:0]          gnt;
  logic [1:0]          done;
  logic [1:0]          err;
  logic                busy;

  modport master (
    output req, req_dir, req_len0, req_len1,
    input  gnt, done, err, busy
  );

  modport slave (
    input  req, req_dir, req_len0, req_len1,
    output gnt, done, err, busy
  );
endinterface

// File: rtl/cnt_arb_ctrl.sv
// Round-robin sequencer sharing one up/down counter between two requesters,
// with overflow recovery by pulsing the counter's reset.
module cnt_arb_ctrl #(
  parameter int CNTR_WDTH = 4,
  parameter int LEN_WDTH  = 4,
  parameter int RST_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cnt_arb_ctrl_if.slave        bus,
  output logic                 act_o,
  output logic                 up_dwn_o,
  output logic                 cnt_rst_n,
  input  logic                 ovrflw_i,
  input  logic [CNTR_WDTH-1:0] count_i
);
  localparam int              RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RECOV} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          gnt_reg, gnt_next;
  logic [1:0]          done_reg, done_next;
  logic [1:0]          err_reg, err_next;
  logic                busy_reg, busy_next;
  logic                act_reg, act_next;
  logic                dir_reg, dir_next;
  logic                cnt_rst_n_reg, cnt_rst_n_next;
  logic [LEN_WDTH-1:0] rem_reg, rem_next;
  logic [RC_W-1:0]     rc_reg, rc_next;
  logic                last_reg, last_next;
  logic                sel;
  logic [LEN_WDTH-1:0] len_sel;
  logic                unused_status;

  // count_i is observation only; nothing in the control path depends on it
  assign unused_status = ^count_i;

  // last_reg=1 means requester 1 was served last, so a tie goes to requester 0
  assign sel     = (bus.req == 2'b11) ? ~last_reg : bus.req[1];
  assign len_sel = sel ? bus.req_len1 : bus.req_len0;

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    done_next      = 2'b00;
    err_next       = 2'b00;
    act_next       = act_reg;
    dir_next       = dir_reg;
    cnt_rst_n_next = 1'b1;
    rem_next       = rem_reg;
    rc_next        = rc_reg;
    last_next      = last_reg;

    if (state_reg != RECOV && ovrflw_i) begin
      state_next     = RECOV;
      act_next       = 1'b0;
      cnt_rst_n_next = 1'b0;
      rc_next        = RC_INIT;
      err_next       = (RST_CYC == 1) ? gnt_reg : 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            gnt_next = sel ? 2'b10 : 2'b01;
            dir_next = bus.req_dir[sel];
            if (len_sel != '0) begin
              state_next = RUN;
              act_next   = 1'b1;
              rem_next   = len_sel;
            end else begin
              state_next = DRAIN;
            end
          end
        end
        RUN: begin
          if (rem_reg == LEN_WDTH'(1)) begin
            state_next = DRAIN;
            act_next   = 1'b0;
            done_next  = gnt_reg;
          end else begin
            rem_next = rem_reg - LEN_WDTH'(1);
          end
        end
        DRAIN: begin
          // A zero-length run arrives here without done raised; spend one
          // cycle raising it so the grant is visible before completion.
          if (done_reg == 2'b00) begin
            done_next = gnt_reg;
          end else begin
            state_next = IDLE;
            gnt_next   = 2'b00;
            dir_next   = 1'b0;
            last_next  = gnt_reg[1];
          end
        end
        RECOV: begin
          if (rc_reg == '0) begin
            state_next = IDLE;
            gnt_next   = 2'b00;
            dir_next   = 1'b0;
            if (|gnt_reg)
              last_next = gnt_reg[1];
          end else begin
            cnt_rst_n_next = 1'b0;
            rc_next        = rc_reg - RC_W'(1);
            if (rc_reg == RC_W'(1))
              err_next = gnt_reg;
          end
        end
        default: begin
          state_next = IDLE;
          gnt_next   = 2'b00;
          act_next   = 1'b0;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= 2'b00;
      done_reg      <= 2'b00;
      err_reg       <= 2'b00;
      busy_reg      <= 1'b0;
      act_reg       <= 1'b0;
      dir_reg       <= 1'b0;
      cnt_rst_n_reg <= 1'b0;
      rem_reg       <= '0;
      rc_reg        <= '0;
      last_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      act_reg       <= act_next;
      dir_reg       <= dir_next;
      cnt_rst_n_reg <= cnt_rst_n_next;
      rem_reg       <= rem_next;
      rc_reg        <= rc_next;
      last_reg      <= last_next;
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.done  = done_reg;
  assign bus.err   = err_reg;
  assign bus.busy  = busy_reg;
  assign act_o     = act_reg;
  assign up_dwn_o  = dir_reg;
  assign cnt_rst_n = cnt_rst_n_reg;
endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// Bench for cnt_arb_ctrl: directed cycle checks plus random runs scored by a
// run-level model of grant order, act count, outcome and final counter value.
module tb_cnt_arb_ctrl;
  logic       clk;
  logic       rst;
  logic       act, up_dwn, cnt_rst_n, ovrflw;
  logic [3:0] count;
  int         total = 0;
  int         bad   = 0;
  logic       last_m;
  int         cnt_m;
  int         t2_gnt [7] = '{1, 1, 0, 2, 2, 0, 1};

  cnt_arb_ctrl_if #(.LEN_WDTH(4)) bus ();

  cnt_arb_ctrl #(.CNTR_WDTH(4), .LEN_WDTH(4), .RST_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .act_o     (act),
    .up_dwn_o  (up_dwn),
    .cnt_rst_n (cnt_rst_n),
    .ovrflw_i  (ovrflw),
    .count_i   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Up/down counter with sticky wrap flag, standing in for the real counter
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      count  <= 4'd0;
      ovrflw <= 1'b0;
    end else if (act) begin
      if (up_dwn) begin
        if (count == 4'd15) ovrflw <= 1'b1;
        count <= count + 4'd1;
      end else begin
        if (count == 4'd0) ovrflw <= 1'b1;
        count <= count - 4'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] dr, input logic [3:0] l0, input logic [3:0] l1);
    bus.req      = rq;
    bus.req_dir  = dr;
    bus.req_len0 = l0;
    bus.req_len1 = l1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    @(negedge clk);
    chk("rst gnt", 32'(bus.gnt), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst act", 32'(act), 0);
    chk("rst up_dwn", 32'(up_dwn), 0);
    chk("rst cnt_rst_n", 32'(cnt_rst_n), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst release cnt_rst_n", 32'(cnt_rst_n), 1);
    last_m = 1'b1;
    cnt_m  = 0;
  endtask

  // One run: the model predicts winner, act cycles, outcome and final count.
  task automatic txn(input logic [1:0] rq, input logic [1:0] dr, input logic [3:0] l0_in, input logic [3:0] l1_in);
    logic       sel, dir_m, ovf, got;
    logic [3:0] l0, l1;
    logic [1:0] exp_gnt, seen_done, seen_err;
    int         len, k, exp_act, exp_cnt, act_n, dir_bad, hold_bad, both_bad, wait_n;
    l0      = l0_in;
    l1      = l1_in;
    sel     = (rq == 2'b11) ? ~last_m : rq[1];
    len     = sel ? int'(l1) : int'(l0);
    dir_m   = dr[sel];
    k       = dir_m ? 16 - cnt_m : cnt_m + 1;   // act cycles until the counter wraps
    // A wrap on the very last act cycle is left out of the random mix.
    if (len == k) begin
      len = len - 1;
      if (sel) l1 = 4'(len); else l0 = 4'(len);
    end
    ovf     = (len > k);
    exp_act = ovf ? k + 1 : len;
    exp_cnt = ovf ? 0 : (dir_m ? cnt_m + len : cnt_m - len);
    exp_gnt = sel ? 2'b10 : 2'b01;
    drive(rq, dr, l0, l1);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) got = 1'b1;
    end
    chk("txn grant", 32'(bus.gnt), 32'(exp_gnt));
    // scramble requests after grant; the run must ignore them
    drive(2'b00, 2'($urandom), 4'($urandom), 4'($urandom));
    act_n = 0; dir_bad = 0; hold_bad = 0; both_bad = 0; wait_n = 0;
    seen_done = 2'b00; seen_err = 2'b00;
    while (bus.gnt != 2'b00 && wait_n < 40) begin
      if (act) act_n++;
      if (up_dwn !== dir_m) dir_bad++;
      if (bus.gnt !== exp_gnt) hold_bad++;
      if ((|bus.done) && (|bus.err)) both_bad++;
      seen_done |= bus.done;
      seen_err  |= bus.err;
      @(negedge clk);
      wait_n++;
    end
    chk("txn finished in bound", 32'(wait_n < 40), 1);
    chk("txn act cycles", 32'(act_n), 32'(exp_act));
    chk("txn up_dwn held", 32'(dir_bad), 0);
    chk("txn gnt held", 32'(hold_bad), 0);
    chk("txn done+err together", 32'(both_bad), 0);
    chk("txn done", 32'(seen_done), ovf ? 0 : 32'(exp_gnt));
    chk("txn err", 32'(seen_err), ovf ? 32'(exp_gnt) : 0);
    chk("txn count", 32'(count), 32'(exp_cnt));
    chk("txn busy after", 32'(bus.busy), 0);
    chk("txn cnt_rst_n after", 32'(cnt_rst_n), 1);
    $display("txn rq=%b sel=%0d dir=%0d len=%0d ovf=%0d act=%0d count=%0d", rq, sel, dir_m, len, ovf, act_n, count);
    last_m = sel;
    cnt_m  = exp_cnt;
  endtask

  initial begin
    rst = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0);

    // Up run of 3 on requester 0, cycle exact
    do_reset();
    drive(2'b01, 2'b01, 4'd3, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t1 gnt c%0d", c), 32'(bus.gnt), (c <= 4) ? 1 : 0);
      chk($sformatf("t1 act c%0d", c), 32'(act), (c <= 3) ? 1 : 0);
      chk($sformatf("t1 done c%0d", c), 32'(bus.done), (c == 4) ? 1 : 0);
      if (c <= 3) chk($sformatf("t1 up_dwn c%0d", c), 32'(up_dwn), 1);
      if (c == 1) drive(2'b00, 2'b00, 4'd0, 4'd0);
    end
    chk("t1 count", 32'(count), 3);

    // Both requesting, held: grants alternate with one idle gap
    do_reset();
    drive(2'b11, 2'b11, 4'd1, 4'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("t2 gnt c%0d", c), 32'(bus.gnt), 32'(t2_gnt[c-1]));
    end

    // Zero-length run on requester 1 leaves the count alone
    do_reset();
    txn(2'b01, 2'b01, 4'd4, 4'd0);
    drive(2'b10, 2'b10, 4'd0, 4'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("t3 gnt c%0d", c), 32'(bus.gnt), (c <= 2) ? 2 : 0);
      chk($sformatf("t3 done c%0d", c), 32'(bus.done), (c == 2) ? 2 : 0);
      chk($sformatf("t3 act c%0d", c), 32'(act), 0);
      if (c == 1) drive(2'b00, 2'b00, 4'd0, 4'd0);
    end
    chk("t3 count", 32'(count), 4);

    // Overflow recovery, cycle exact
    do_reset();
    txn(2'b01, 2'b01, 4'd15, 4'd0);
    drive(2'b01, 2'b01, 4'd2, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4 gnt c%0d", c), 32'(bus.gnt), (c <= 4) ? 1 : 0);
      chk($sformatf("t4 act c%0d", c), 32'(act), (c <= 2) ? 1 : 0);
      chk($sformatf("t4 cnt_rst_n c%0d", c), 32'(cnt_rst_n), (c == 3 || c == 4) ? 0 : 1);
      chk($sformatf("t4 err c%0d", c), 32'(bus.err), (c == 4) ? 1 : 0);
      chk($sformatf("t4 done c%0d", c), 32'(bus.done), 0);
      if (c == 1) drive(2'b00, 2'b00, 4'd0, 4'd0);
    end
    chk("t4 count", 32'(count), 0);

    // Reset in the middle of a long run
    do_reset();
    drive(2'b01, 2'b01, 4'd8, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5 act c%0d", c), 32'(act), 1);
      if (c == 1) drive(2'b00, 2'b00, 4'd0, 4'd0);
    end
    rst = 1'b0;
    #1;
    chk("t5 act", 32'(act), 0);
    chk("t5 gnt", 32'(bus.gnt), 0);
    chk("t5 busy", 32'(bus.busy), 0);
    chk("t5 cnt_rst_n", 32'(cnt_rst_n), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5 idle gnt+busy c%0d", c), 32'({bus.gnt, bus.busy}), 0);
      chk($sformatf("t5 idle done+err c%0d", c), 32'({bus.done, bus.err}), 0);
    end
    last_m = 1'b1;
    cnt_m  = 0;

    // Down run of 2 from 5, request dropped right after grant
    txn(2'b01, 2'b01, 4'd5, 4'd0);
    txn(2'b01, 2'b00, 4'd2, 4'd0);

    // Random runs
    for (int n = 0; n < 40; n++)
      txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
